// File: rtl/mul_iter_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state type and
// iteration-counter sizing.
package mul_iter_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold the value n itself, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CNT_W = cnt_width(32);

endpackage

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier with start/busy/done handshake.
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module mul_iter_unit
  import mul_iter_unit_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [size-1:0] src1_i,
  input  logic [size-1:0] src2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [size-1:0] result_lo_o,
  output logic [size-1:0] result_hi_o
);

  localparam int CNT_WIDTH = cnt_width(size);
  localparam int W2        = 2 * size;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sign_q, sign_d;
  logic [size-1:0]        mcand_q, mcand_d;
  logic [size-1:0]        mplier_q, mplier_d;
  logic [size-1:0]        res_lo_q, res_lo_d;
  logic [size-1:0]        res_hi_q, res_hi_d;
  logic [W2-1:0]          acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [size:0]          sum;
  logic [W2-1:0]          acc_src;
  logic [W2-1:0]          acc_fin;
  logic                   finish;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    sum = {1'b0, acc_q[W2-1:size]} + {1'b0, (mplier_q[0] ? mcand_q : {size{1'b0}})};

`ifdef MUL_EARLY_TERM_EN
    // Remaining iterations would only shift, so collapse them into one shift.
    finish  = (cnt_q == CNT_WIDTH'(size)) || (mplier_q == '0);
    acc_src = acc_q >> (CNT_WIDTH'(size) - cnt_q);
`else
    finish  = (cnt_q == CNT_WIDTH'(size));
    acc_src = acc_q;
`endif
    acc_fin = sign_q ? ('0 - acc_src) : acc_src;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          mcand_d  = (signed_i && src1_i[size-1]) ? ('0 - src1_i) : src1_i;
          mplier_d = (signed_i && src2_i[size-1]) ? ('0 - src2_i) : src2_i;
          sign_d   = signed_i & (src1_i[size-1] ^ src2_i[size-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        // The RUN cycle after the last iteration applies the sign and registers the product.
        if (finish) begin
          state_d              = DONE;
          done_d               = 1'b1;
          {res_hi_d, res_lo_d} = acc_fin;
        end else begin
          acc_d    = {sum, acc_q[size-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_lo_o = res_lo_q;
  assign result_hi_o = res_hi_q;

endmodule
